// File: rtl/bidir_bus_seq.sv
// bidir_bus_seq
//   Registered sequencer for a row of single-bit tristate pad buffers.
//   Converts core-side write/read requests into pad drive windows, inserts a
//   guaranteed-tristate turnaround after every drive, and samples the pad
//   through a two-flop synchroniser with a fixed read latency.
//
// Ports
//   CLK        in   1      rising-edge clock
//   CLR        in   1      asynchronous active-high reset
//   req_valid  in   1      request present
//   req_we     in   1      1 = write (drive pad), 0 = read (sample pad)
//   req_data   in   WIDTH  write data
//   req_ready  out  1      request accepted on the edge where req_valid & req_ready
//   rd_data    out  WIDTH  captured read data, held until the next capture
//   rd_valid   out  1      one-cycle pulse, rd_data updated this cycle
//   busy       out  1      sequencer not idle
//   gts        in   1      global tristate, forces pad_t high without touching the FSM
//   pad_o      out  WIDTH  to buffer I
//   pad_t      out  1      to buffer T (1 = tristate)
//   pad_i      in   WIDTH  from buffer O
module bidir_bus_seq #(
    parameter int WIDTH  = 8,
    parameter int HOLD   = 1,
    parameter int TURN   = 2,
    parameter int RD_LAT = 3
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    input  logic             gts,
    output logic [WIDTH-1:0] pad_o,
    output logic             pad_t,
    input  logic [WIDTH-1:0] pad_i
);

    localparam int MAX_HT  = (HOLD > TURN) ? HOLD : TURN;
    localparam int MAX_ALL = (MAX_HT > RD_LAT) ? MAX_HT : RD_LAT;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    // The read load is RD_LAT-2 so that the capture edge lands RD_LAT-1
    // edges after the accept edge; back-to-back reads then pulse rd_valid
    // exactly RD_LAT cycles apart.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN - 1);
    localparam logic [CW-1:0] READ_LOAD = CW'(RD_LAT - 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURNS = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             t_reg, t_next;
    logic [WIDTH-1:0] pad_o_next;
    logic [WIDTH-1:0] rd_data_next;
    logic             rd_valid_next;
    logic [WIDTH-1:0] sync1, sync2;
    logic             accept;

    assign req_ready = (state == IDLE) & ~CLR;
    assign accept    = req_valid & req_ready;
    assign busy      = (state != IDLE);
    assign pad_t     = t_reg | gts;

    // Two-flop synchroniser on the pad input, running every cycle.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pad_i;
            sync2 <= sync1;
        end
    end

    // State and datapath registers; CLR releases the pad immediately.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            cnt      <= '0;
            t_reg    <= 1'b1;
            pad_o    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            t_reg    <= t_next;
            pad_o    <= pad_o_next;
            rd_data  <= rd_data_next;
            rd_valid <= rd_valid_next;
        end
    end

    // Next-state logic. The counter only decrements when nonzero, so it
    // saturates at 0 and never wraps.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        t_next        = 1'b1;
        pad_o_next    = pad_o;
        rd_data_next  = rd_data;
        rd_valid_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        pad_o_next = req_data;
                        t_next     = 1'b0;
                        cnt_next   = HOLD_LOAD;
                        state_next = DRIVE;
                    end else begin
                        cnt_next   = READ_LOAD;
                        state_next = READ;
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    t_next     = 1'b1;
                    cnt_next   = TURN_LOAD;
                    state_next = TURNS;
                end else begin
                    t_next   = 1'b0;
                    cnt_next = cnt - CNT_ONE;
                end
            end
            TURNS: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    rd_data_next  = sync2;
                    rd_valid_next = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bidir_bus_seq.sv
// tb_bidir_bus_seq
//   Directed bench for bidir_bus_seq with default parameters
//   (WIDTH=8, HOLD=1, TURN=2, RD_LAT=3). Inputs change 1 time unit after
//   each rising edge and outputs are sampled at that same point.
module tb_bidir_bus_seq;

    logic       CLK;
    logic       CLR;
    logic       req_valid;
    logic       req_we;
    logic [7:0] req_data;
    logic       req_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       gts;
    logic [7:0] pad_o;
    logic       pad_t;
    logic [7:0] pad_i;

    int total_count;
    int bad_count;

    bidir_bus_seq #(
        .WIDTH (8),
        .HOLD  (1),
        .TURN  (2),
        .RD_LAT(3)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_data (req_data),
        .req_ready(req_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .gts      (gts),
        .pad_o    (pad_o),
        .pad_t    (pad_t),
        .pad_i    (pad_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected)
        else begin
            bad_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        CLR         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_data    = 8'h00;
        gts         = 1'b0;
        pad_i       = 8'h00;

        // Reset state
        #2;
        check("rst_pad_t", 32'(pad_t), 32'h1);
        check("rst_pad_o", 32'(pad_o), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready_in_clr", 32'(req_ready), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        tick();
        CLR = 1'b0;
        #1;
        check("rst_ready_after", 32'(req_ready), 32'h1);

        // Write A5: one drive cycle, two tristate cycles, ready on the third
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_data  = 8'hA5;
        tick();
        req_valid = 1'b0;
        req_data  = 8'h77;
        check("wr_drive_t", 32'(pad_t), 32'h0);
        check("wr_drive_o", 32'(pad_o), 32'hA5);
        check("wr_drive_busy", 32'(busy), 32'h1);
        check("wr_drive_ready", 32'(req_ready), 32'h0);
        tick();
        check("wr_turn1_t", 32'(pad_t), 32'h1);
        check("wr_turn1_ready", 32'(req_ready), 32'h0);
        tick();
        check("wr_turn2_t", 32'(pad_t), 32'h1);
        check("wr_turn2_busy", 32'(busy), 32'h1);
        tick();
        check("wr_idle_ready", 32'(req_ready), 32'h1);
        check("wr_idle_busy", 32'(busy), 32'h0);
        check("wr_idle_o_kept", 32'(pad_o), 32'hA5);

        // Read with static pad value 3C
        pad_i = 8'h3C;
        tick();
        tick();
        req_valid = 1'b1;
        req_we    = 1'b0;
        tick();
        req_valid = 1'b0;
        check("rd_accept_busy", 32'(busy), 32'h1);
        check("rd_accept_t", 32'(pad_t), 32'h1);
        check("rd_accept_valid", 32'(rd_valid), 32'h0);
        tick();
        check("rd_wait_valid", 32'(rd_valid), 32'h0);
        check("rd_wait_t", 32'(pad_t), 32'h1);
        tick();
        check("rd_cap_valid", 32'(rd_valid), 32'h1);
        check("rd_cap_data", 32'(rd_data), 32'h3C);
        check("rd_cap_busy", 32'(busy), 32'h0);
        tick();
        check("rd_after_valid", 32'(rd_valid), 32'h0);
        check("rd_after_data", 32'(rd_data), 32'h3C);

        // Write 11 then read with req_valid held high
        pad_i     = 8'h5A;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_data  = 8'h11;
        tick();
        req_we   = 1'b0;
        req_data = 8'hFF;
        check("wr_rd_drive_o", 32'(pad_o), 32'h11);
        check("wr_rd_drive_t", 32'(pad_t), 32'h0);
        tick();
        check("wr_rd_gap1_t", 32'(pad_t), 32'h1);
        check("wr_rd_gap1_ready", 32'(req_ready), 32'h0);
        tick();
        check("wr_rd_gap2_t", 32'(pad_t), 32'h1);
        check("wr_rd_gap2_ready", 32'(req_ready), 32'h0);
        tick();
        check("wr_rd_idle_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        check("wr_rd_read_busy", 32'(busy), 32'h1);
        check("wr_rd_read_t", 32'(pad_t), 32'h1);
        tick();
        check("wr_rd_wait_valid", 32'(rd_valid), 32'h0);
        tick();
        check("wr_rd_cap_valid", 32'(rd_valid), 32'h1);
        check("wr_rd_cap_data", 32'(rd_data), 32'h5A);
        check("wr_rd_pad_o_kept", 32'(pad_o), 32'h11);
        tick();

        // gts held during a write
        gts       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_data  = 8'hC3;
        #1;
        check("gts_idle_t", 32'(pad_t), 32'h1);
        tick();
        req_valid = 1'b0;
        check("gts_drive_t", 32'(pad_t), 32'h1);
        check("gts_drive_busy", 32'(busy), 32'h1);
        check("gts_drive_o", 32'(pad_o), 32'hC3);
        tick();
        check("gts_turn1_t", 32'(pad_t), 32'h1);
        check("gts_turn1_ready", 32'(req_ready), 32'h0);
        tick();
        check("gts_turn2_t", 32'(pad_t), 32'h1);
        check("gts_turn2_busy", 32'(busy), 32'h1);
        tick();
        check("gts_idle_ready", 32'(req_ready), 32'h1);
        check("gts_idle_busy", 32'(busy), 32'h0);
        gts = 1'b0;

        // Back-to-back reads, pad value changes between them
        pad_i = 8'h01;
        tick();
        tick();
        req_valid = 1'b1;
        req_we    = 1'b0;
        tick();
        check("b2b_acc1_busy", 32'(busy), 32'h1);
        tick();
        check("b2b_wait1_valid", 32'(rd_valid), 32'h0);
        tick();
        check("b2b_cap1_valid", 32'(rd_valid), 32'h1);
        check("b2b_cap1_data", 32'(rd_data), 32'h01);
        check("b2b_cap1_ready", 32'(req_ready), 32'h1);
        pad_i = 8'h02;
        tick();
        check("b2b_acc2_valid", 32'(rd_valid), 32'h0);
        check("b2b_acc2_busy", 32'(busy), 32'h1);
        tick();
        req_valid = 1'b0;
        check("b2b_wait2_valid", 32'(rd_valid), 32'h0);
        tick();
        check("b2b_cap2_valid", 32'(rd_valid), 32'h1);
        check("b2b_cap2_data", 32'(rd_data), 32'h02);
        tick();
        check("b2b_after_valid", 32'(rd_valid), 32'h0);

        // Asynchronous reset in the middle of a drive window
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_data  = 8'h96;
        tick();
        req_valid = 1'b0;
        check("clr_pre_t", 32'(pad_t), 32'h0);
        check("clr_pre_o", 32'(pad_o), 32'h96);
        #1;
        CLR = 1'b1;
        #1;
        check("clr_mid_t", 32'(pad_t), 32'h1);
        check("clr_mid_o", 32'(pad_o), 32'h00);
        check("clr_mid_busy", 32'(busy), 32'h0);
        check("clr_mid_rd_data", 32'(rd_data), 32'h00);
        CLR = 1'b0;
        #1;
        check("clr_rel_ready", 32'(req_ready), 32'h1);
        check("clr_rel_t", 32'(pad_t), 32'h1);
        tick();
        check("clr_idle_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
